// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave).
// req/gnt/rvalid handshake; address, byte enables and write data come from the master.
interface mem_stage_lsu_if;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_WDATA;
  logic        DMEM_GNT;
  logic        DMEM_RVALID;
  logic [31:0] DMEM_RDATA;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
    input  DMEM_GNT, DMEM_RVALID, DMEM_RDATA
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA,
    output DMEM_GNT, DMEM_RVALID, DMEM_RDATA
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into one data-memory
// transaction, stalls the pipeline while it runs and returns extended load data.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 15
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_MEM_READ,
  input  logic         IN_MEM_WRITE,
  input  logic [2:0]   IN_FUNCT3,
  input  logic [31:0]  IN_ADDR,
  input  logic [31:0]  IN_STORE_DATA,
  mem_stage_lsu_if.master dmem,
  output logic [31:0]  OUT_DMEM_OUT,
  output logic         OUT_STALL,
  output logic         OUT_ACCESS_ERR,
  output logic         OUT_TIMEOUT
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [29:0]   addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [31:0]   dmem_out_q;
  logic          timeout_q;

  logic          access, is_load, funct3_ok, misaligned, access_err, start;
  logic [1:0]    off;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic          stall, capture, tmo, load_done, cnt_hit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  assign off = IN_ADDR[1:0];

  // Decode of the access sitting in EX/MEM: legality and store lane placement.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    access    = IN_MEM_READ | IN_MEM_WRITE;
    is_load   = IN_MEM_READ;
    funct3_ok = 1'b0;
    case (IN_FUNCT3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = is_load;
      default:                funct3_ok = 1'b0;
    endcase
    misaligned = ((IN_FUNCT3[1:0] == 2'b01) && off[0]) ||
                 ((IN_FUNCT3[1:0] == 2'b10) && (off != 2'b00));
    access_err = access & (~funct3_ok | misaligned);
    start      = access & ~access_err;

    be_d    = 4'b1111;
    wdata_d = IN_STORE_DATA;
    if (!is_load) begin
      case (IN_FUNCT3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{IN_STORE_DATA[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << off;
          wdata_d = {2{IN_STORE_DATA[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign cnt_hit = (cnt == CW'(MAX_WAIT - 1));

  always_comb begin
    state_d   = state;
    stall     = 1'b0;
    capture   = 1'b0;
    tmo       = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem.DMEM_GNT) begin
          state_d = we_q ? DONE : WAIT;
        end else if (cnt_hit) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.DMEM_RVALID) begin
          load_done = 1'b1;
          state_d   = DONE;
        end else if (cnt_hit) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0: byte_sel = dmem.DMEM_RDATA[7:0];
      2'd1: byte_sel = dmem.DMEM_RDATA[15:8];
      2'd2: byte_sel = dmem.DMEM_RDATA[23:16];
      2'd3: byte_sel = dmem.DMEM_RDATA[31:24];
      default: ;
    endcase
    half_sel = off_q[1] ? dmem.DMEM_RDATA[31:16] : dmem.DMEM_RDATA[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem.DMEM_RDATA;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      dmem_out_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state     <= state_d;
      timeout_q <= tmo;
      // The wait counter restarts on every state change and only runs in REQ/WAIT.
      if (state_d != state)
        cnt <= '0;
      else if (state == REQ || state == WAIT)
        cnt <= cnt + 1'b1;
      if (capture) begin
        addr_q   <= IN_ADDR[31:2];
        we_q     <= ~IN_MEM_READ;
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        funct3_q <= IN_FUNCT3;
        off_q    <= off;
      end
      if (tmo)
        dmem_out_q <= '0;
      else if (load_done)
        dmem_out_q <= load_ext;
    end
  end

  assign dmem.DMEM_REQ   = (state == REQ);
  assign dmem.DMEM_WE    = we_q;
  assign dmem.DMEM_ADDR  = {addr_q, 2'b00};
  assign dmem.DMEM_BE    = be_q;
  assign dmem.DMEM_WDATA = wdata_q;

  // Stall is partly combinational from EX/MEM, so reset must mask it while held.
  assign OUT_STALL      = stall & ~RESET;
  assign OUT_ACCESS_ERR = access_err;
  assign OUT_TIMEOUT    = timeout_q;
  assign OUT_DMEM_OUT   = dmem_out_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized loads/stores against a
// transaction-level model of the expected bus, stall length and load result.
module tb_mem_stage_lsu;
  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] dmem_out;
  logic        stall, access_err, timeout;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_out = 32'd0;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IN_MEM_READ    (mem_read),
    .IN_MEM_WRITE   (mem_write),
    .IN_FUNCT3      (funct3),
    .IN_ADDR        (addr_in),
    .IN_STORE_DATA  (store_data),
    .dmem           (dmem),
    .OUT_DMEM_OUT   (dmem_out),
    .OUT_STALL      (stall),
    .OUT_ACCESS_ERR (access_err),
    .OUT_TIMEOUT    (timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Expected load result from the rules: shift the lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * int'(o));
    case (f3)
      3'd0:    return sh[7]  ? ((sh & 32'hFF)   | 32'hFFFFFF00) : (sh & 32'hFF);
      3'd4:    return sh & 32'hFF;
      3'd1:    return sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
      3'd5:    return sh & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_err(input logic rd, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << int'(f3[1:0]);
    return !legal || ((int'(a[1:0]) % size) != 0);
  endfunction

  // Illegal access: flagged, never requested, never stalls, output untouched.
  task automatic run_error(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr_in = a; store_data = $urandom;
    #1;
    check({name, "_err"}, access_err, 1'b1);
    check({name, "_stall"}, stall, 1'b0);
    for (int c = 0; c < 2; c++) begin
      dmem.DMEM_GNT = 1'($urandom_range(0, 1));
      tick();
      check({name, "_noreq"}, dmem.DMEM_REQ, 1'b0);
      check({name, "_stall_hold"}, stall, 1'b0);
      check({name, "_out"}, dmem_out, exp_out);
    end
    dmem.DMEM_GNT = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Legal access: act as memory slave with given grant/rvalid delays (in cycles
  // of REQ/WAIT) and compare bus, stall length, timeout and load result.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sdata, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rdata);
    logic        is_load;
    int          o, req_n, wait_n, seen_req, seen_wait, stalls;
    bit          tmo, in_wait, done, bus_checked;
    logic [31:0] exp_be, exp_wd;

    is_load = rd;
    o       = int'(a[1:0]);
    tmo     = 1'b0;
    wait_n  = 0;
    if (gnt_dly < MW) req_n = gnt_dly + 1;
    else begin req_n = MW; tmo = 1'b1; end
    if (is_load && !tmo) begin
      if (rv_dly < MW) wait_n = rv_dly + 1;
      else begin wait_n = MW; tmo = 1'b1; end
    end
    exp_be = 32'hF;
    exp_wd = sdata;
    if (!is_load) begin
      case (f3[1:0])
        2'd0: begin exp_be = 32'h1 << o; exp_wd = sdata[7:0]  * 32'h01010101; end
        2'd1: begin exp_be = 32'h3 << o; exp_wd = sdata[15:0] * 32'h00010001; end
        default: ;
      endcase
    end

    mem_read = rd; mem_write = wr; funct3 = f3; addr_in = a; store_data = sdata;
    #1;
    check({name, "_err"}, access_err, 1'b0);
    seen_req = 0; seen_wait = 0; stalls = 0;
    in_wait = 1'b0; done = 1'b0; bus_checked = 1'b0;
    for (int c = 0; c < 60; c++) begin
      dmem.DMEM_GNT = 1'b0;
      dmem.DMEM_RVALID = 1'b0;
      dmem.DMEM_RDATA = $urandom;
      if (c > 0 && !stall) begin
        done = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (dmem.DMEM_REQ) begin
        if (!bus_checked) begin
          check({name, "_addr"}, dmem.DMEM_ADDR, {a[31:2], 2'b00});
          check({name, "_we"}, dmem.DMEM_WE, !is_load);
          check({name, "_be"}, dmem.DMEM_BE, exp_be);
          if (!is_load) check({name, "_wdata"}, dmem.DMEM_WDATA, exp_wd);
          bus_checked = 1'b1;
        end
        if (seen_req == gnt_dly) dmem.DMEM_GNT = 1'b1;
        seen_req++;
      end else if (in_wait) begin
        if (seen_wait == rv_dly) begin
          dmem.DMEM_RVALID = 1'b1;
          dmem.DMEM_RDATA  = rdata;
        end
        seen_wait++;
      end
      tick();
      if (dmem.DMEM_GNT && is_load) in_wait = 1'b1;
      if (dmem.DMEM_RVALID) in_wait = 1'b0;
    end

    if (tmo) exp_out = 32'd0;
    else if (is_load) exp_out = ref_load(f3, a[1:0], rdata);
    check({name, "_done"}, done, 1'b1);
    check({name, "_req_cycles"}, seen_req, req_n);
    check({name, "_stall_cycles"}, stalls, 1 + req_n + wait_n);
    check({name, "_timeout"}, timeout, tmo);
    check({name, "_out"}, dmem_out, exp_out);
    check({name, "_req_done"}, dmem.DMEM_REQ, 1'b0);

    // Stray handshake in DONE must be ignored.
    dmem.DMEM_GNT    = 1'($urandom_range(0, 1));
    dmem.DMEM_RVALID = 1'($urandom_range(0, 1));
    tick();
    dmem.DMEM_GNT = 1'b0; dmem.DMEM_RVALID = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k;

    dmem.DMEM_GNT = 1'b0; dmem.DMEM_RVALID = 1'b0; dmem.DMEM_RDATA = 32'd0;
    #1;
    check("rst_req", dmem.DMEM_REQ, 1'b0);
    check("rst_we", dmem.DMEM_WE, 1'b0);
    check("rst_addr", dmem.DMEM_ADDR, 32'd0);
    check("rst_be", dmem.DMEM_BE, 4'd0);
    check("rst_wdata", dmem.DMEM_WDATA, 32'd0);
    check("rst_out", dmem_out, 32'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_err", access_err, 1'b0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    run_access("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0);
    run_access("sb", 1'b0, 1'b1, 3'b000, 32'h102, 32'h12345677, 0, 0, 32'h0);
    run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80ABCDEF);
    check("lb_value", dmem_out, 32'hFFFFFF80);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80ABCDEF);
    check("lbu_value", dmem_out, 32'h00000080);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80ABCDEF);
    check("lhu_value", dmem_out, 32'h000080AB);

    run_error("lh_misaligned", 1'b1, 1'b0, 3'b001, 32'h101);
    run_error("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_error("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h100);

    run_access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 99, 0, 32'h0);
    #1;
    check("post_timeout_pulse", timeout, 1'b0);
    check("post_timeout_stall", stall, 1'b0);
    check("post_timeout_req", dmem.DMEM_REQ, 1'b0);

    // Back-to-back: second access starts the cycle right after DONE.
    run_access("b2b_sh", 1'b0, 1'b1, 3'b001, 32'h206, 32'hCAFEF00D, 1, 0, 32'h0);
    run_access("b2b_lh", 1'b1, 1'b1, 3'b001, 32'h10E, 32'h0, 0, 2, 32'h9234_5678);

    // Reset pulse while waiting for read data.
    mem_read = 1'b1; funct3 = 3'b010; addr_in = 32'h300;
    tick();
    dmem.DMEM_GNT = 1'b1;
    tick();
    dmem.DMEM_GNT = 1'b0;
    #1;
    check("wait_stall", stall, 1'b1);
    RESET = 1'b1;
    #1;
    exp_out = 32'd0;
    check("rst_mid_req", dmem.DMEM_REQ, 1'b0);
    check("rst_mid_stall", stall, 1'b0);
    check("rst_mid_out", dmem_out, exp_out);
    mem_read = 1'b0;
    RESET = 1'b0;
    tick();
    run_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 1, 1, 32'h1357_9BDF);

    // Idle cycles with stray handshakes.
    for (int c = 0; c < 3; c++) begin
      dmem.DMEM_GNT = 1'b1; dmem.DMEM_RVALID = 1'b1; dmem.DMEM_RDATA = $urandom;
      tick();
      check("idle_req", dmem.DMEM_REQ, 1'b0);
      check("idle_out", dmem_out, exp_out);
    end
    dmem.DMEM_GNT = 1'b0; dmem.DMEM_RVALID = 1'b0;

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd) begin
        k  = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      if (ref_err(rd, f3, a))
        run_error("rnd_err", rd, wr, f3, a);
      else
        run_access("rnd", rd, wr, f3, a, $urandom, $urandom_range(0, MW),
                   $urandom_range(0, MW), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
